// File: rtl/rf_pkg.sv
// Shared constants for the multi-port register file: default geometry and
// the MIPS register aliases that benches and issue logic refer to by name.
package rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;

  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 31;

endpackage : rf_pkg

// File: rtl/rf_read_port.sv
// One read port of register_file_mp: storage mux, write-through forwarding
// and the busy bit of the addressed register.
module rf_read_port #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] regs [DEPTH],
  input  logic [DEPTH-1:0]  busy,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy
);

  logic zero_hit;
  logic hit0;
  logic hit1;

  assign zero_hit = ZERO_REG && (rd_addr == '0);
  assign hit0     = BYPASS && we0 && (wa0 == rd_addr);
  assign hit1     = BYPASS && we1 && (wa1 == rd_addr);

  // Port 1 is checked first so it wins when both writers target this address.
  always_comb begin
    if (zero_hit) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end else if (hit1) begin
      rd_data = wd1;
      rd_busy = 1'b0;
    end else if (hit0) begin
      rd_data = wd0;
      rd_busy = 1'b0;
    end else begin
      rd_data = regs[rd_addr];
      rd_busy = busy[rd_addr];
    end
  end

endmodule : rf_read_port

// File: rtl/register_file_mp.sv
// Multi-port register file for a pipelined MIPS core: two writers, NUM_RD
// combinational readers and a per-register pending-write scoreboard.
module register_file_mp
  import rf_pkg::*;
#(
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int DEPTH    = DEPTH_DEF,
  parameter  int NUM_RD   = 2,
  parameter  bit ZERO_REG = 1'b1,
  parameter  bit BYPASS   = 1'b1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] readAddr,
  output logic [NUM_RD*DATA_W-1:0] readData,
  output logic [NUM_RD-1:0]        readBusy,
  input  logic                     writeEnable0,
  input  logic [ADDR_W-1:0]        writeAddr0,
  input  logic [DATA_W-1:0]        writeData0,
  input  logic                     writeEnable1,
  input  logic [ADDR_W-1:0]        writeAddr1,
  input  logic [DATA_W-1:0]        writeData1,
  input  logic                     reserveEnable,
  input  logic [ADDR_W-1:0]        reserveAddr,
  output logic [DEPTH-1:0]         busyVec
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  // NOTE: every output of this block starts from its held value, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    // NOTE: blocking assignments in sequence give later statements priority:
    // port 1 data overrides port 0, and a reservation overrides a write clear.
    if (writeEnable0) begin
      mem_d[writeAddr0]  = writeData0;
      busy_d[writeAddr0] = 1'b0;
    end
    if (writeEnable1) begin
      mem_d[writeAddr1]  = writeData1;
      busy_d[writeAddr1] = 1'b0;
    end
    if (reserveEnable) begin
      busy_d[reserveAddr] = 1'b1;
    end
    if (ZERO_REG) begin
      mem_d[0]  = '0;
      busy_d[0] = 1'b0;
    end
  end

  // NOTE: the storage array is reset along with the scoreboard so nothing
  // ever reads X; this costs a reset net per flop but is required here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  assign busyVec = busy_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd (
      .rd_addr (readAddr[k*ADDR_W +: ADDR_W]),
      .regs    (mem_q),
      .busy    (busy_q),
      .we0     (writeEnable0),
      .wa0     (writeAddr0),
      .wd0     (writeData0),
      .we1     (writeEnable1),
      .wa1     (writeAddr1),
      .wd1     (writeData1),
      .rd_data (readData[k*DATA_W +: DATA_W]),
      .rd_busy (readBusy[k])
    );
  end

endmodule : register_file_mp

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: a default build (bypass, zero reg,
// two readers) and a BYPASS=0 three-reader build sharing clock and reset.
module tb_register_file_mp;
  import rf_pkg::*;

  logic clk;
  logic reset;

  logic [9:0]  ra_a;
  logic [63:0] rd_a;
  logic [1:0]  rb_a;
  logic        we0_a, we1_a, res_a;
  logic [4:0]  wa0_a, wa1_a, resa_a;
  logic [31:0] wd0_a, wd1_a;
  logic [31:0] bv_a;

  logic [14:0] ra_b;
  logic [95:0] rd_b;
  logic [2:0]  rb_b;
  logic        we0_b, we1_b, res_b;
  logic [4:0]  wa0_b, wa1_b, resa_b;
  logic [31:0] wd0_b, wd1_b;
  logic [31:0] bv_b;

  int checks   = 0;
  int failures = 0;

  register_file_mp dut_a (
    .clk           (clk),
    .reset         (reset),
    .readAddr      (ra_a),
    .readData      (rd_a),
    .readBusy      (rb_a),
    .writeEnable0  (we0_a),
    .writeAddr0    (wa0_a),
    .writeData0    (wd0_a),
    .writeEnable1  (we1_a),
    .writeAddr1    (wa1_a),
    .writeData1    (wd1_a),
    .reserveEnable (res_a),
    .reserveAddr   (resa_a),
    .busyVec       (bv_a)
  );

  register_file_mp #(.NUM_RD(3), .BYPASS(1'b0)) dut_b (
    .clk           (clk),
    .reset         (reset),
    .readAddr      (ra_b),
    .readData      (rd_b),
    .readBusy      (rb_b),
    .writeEnable0  (we0_b),
    .writeAddr0    (wa0_b),
    .writeData0    (wd0_b),
    .writeEnable1  (we1_b),
    .writeAddr1    (wa1_b),
    .writeData1    (wd1_b),
    .reserveEnable (res_b),
    .reserveAddr   (resa_b),
    .busyVec       (bv_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    ra_a = '0; we0_a = 0; we1_a = 0; res_a = 0;
    wa0_a = '0; wa1_a = '0; resa_a = '0; wd0_a = '0; wd1_a = '0;
    ra_b = '0; we0_b = 0; we1_b = 0; res_b = 0;
    wa0_b = '0; wa1_b = '0; resa_b = '0; wd0_b = '0; wd1_b = '0;
    repeat (2) @(posedge clk);
    #1;
    ra_a = {5'd0, 5'd5};
    #1;
    check("rst_data_r5", rd_a[31:0], 64'h0);
    check("rst_busyvec", bv_a, 64'h0);
    check("rst_readbusy", rb_a, 64'h0);
    reset = 1'b1;

    // Reset test: write r5, reserve r3, then pulse reset mid-cycle
    tick();
    we0_a = 1; wa0_a = 5'd5; wd0_a = 32'hDEADBEEF;
    res_a = 1; resa_a = 5'd3;
    ra_a  = {5'd3, 5'd5};
    #1;
    check("bypass_r5", rd_a[31:0], 64'hDEADBEEF);
    tick();
    we0_a = 0; res_a = 0;
    #1;
    check("stored_r5", rd_a[31:0], 64'hDEADBEEF);
    check("busy_r3_set", bv_a[3], 64'h1);
    check("readbusy_r3", rb_a[1], 64'h1);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_data_r5", rd_a[31:0], 64'h0);
    check("midrst_busyvec", bv_a, 64'h0);
    check("midrst_readbusy", rb_a, 64'h0);
    tick();
    reset = 1'b1;

    // Dual write collision on r7: port 1 wins, also under bypass
    tick();
    we0_a = 1; wa0_a = 5'd7; wd0_a = 32'h11111111;
    we1_a = 1; wa1_a = 5'd7; wd1_a = 32'h22222222;
    ra_a  = {5'd7, 5'd7};
    #1;
    check("collide_bypass_p0", rd_a[31:0], 64'h22222222);
    check("collide_bypass_p1", rd_a[63:32], 64'h22222222);
    tick();
    we0_a = 0; we1_a = 0;
    #1;
    check("collide_stored", rd_a[31:0], 64'h22222222);
    // Port 0 alone forwards its own data
    we0_a = 1; wa0_a = 5'd7; wd0_a = 32'h33333333;
    #1;
    check("p0_bypass_r7", rd_a[63:32], 64'h33333333);
    tick();
    we0_a = 0;
    #1;
    check("p0_stored_r7", rd_a[31:0], 64'h33333333);

    // Zero register ignores writes, bypass and reservations
    we1_a = 1; wa1_a = REG_ZERO[4:0]; wd1_a = 32'hFFFFFFFF;
    res_a = 1; resa_a = REG_ZERO[4:0];
    ra_a  = {5'd0, 5'd0};
    #1;
    check("r0_no_bypass", rd_a[31:0], 64'h0);
    tick();
    we1_a = 0; res_a = 0;
    #1;
    check("r0_data", rd_a[63:32], 64'h0);
    check("r0_busy", bv_a[0], 64'h0);

    // Scoreboard: reserve r9 at cycle 0, port 1 writes it at cycle 3
    res_a = 1; resa_a = 5'd9; ra_a = {5'd9, 5'd31};
    tick();
    res_a = 0;
    #1;
    check("r9_readbusy_c1", rb_a[1], 64'h1);
    check("r9_busyvec_c1", bv_a[9], 64'h1);
    tick();
    #1;
    check("r9_readbusy_c2", rb_a[1], 64'h1);
    tick();
    we1_a = 1; wa1_a = 5'd9; wd1_a = 32'h00001234;
    #1;
    check("r9_readbusy_c3", rb_a[1], 64'h0);
    check("r9_data_c3", rd_a[63:32], 64'h1234);
    check("r9_busyvec_c3", bv_a[9], 64'h1);
    tick();
    we1_a = 0;
    #1;
    check("r9_busyvec_c4", bv_a[9], 64'h0);
    check("r9_data_c4", rd_a[63:32], 64'h1234);
    check("r31_untouched", rd_a[31:0], 64'h0);

    // Reserve and write r4 in the same cycle: set wins
    res_a = 1; resa_a = 5'd4;
    we0_a = 1; wa0_a = 5'd4; wd0_a = 32'h55;
    ra_a  = {5'd4, 5'd4};
    tick();
    res_a = 0; we0_a = 0;
    #1;
    check("r4_data", rd_a[31:0], 64'h55);
    check("r4_busyvec", bv_a[4], 64'h1);
    check("r4_readbusy", rb_a[0], 64'h1);

    // BYPASS=0, three readers: reserve r12, then write it while all read it
    res_b = 1; resa_b = 5'd12;
    tick();
    res_b = 0;
    we0_b = 1; wa0_b = 5'd12; wd0_b = 32'h0000A5A5;
    ra_b  = {5'd12, 5'd12, 5'd12};
    #1;
    for (int k = 0; k < 3; k++) begin
      check("nobyp_old_data", rd_b[k*32 +: 32], 64'h0);
      check("nobyp_busy_held", rb_b[k], 64'h1);
    end
    tick();
    we0_b = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("nobyp_new_data", rd_b[k*32 +: 32], 64'hA5A5);
      check("nobyp_busy_clr", rb_b[k], 64'h0);
    end
    check("nobyp_busyvec", bv_b, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_register_file_mp
